mmu_translate: RTL

Address-translation stage sitting directly upstream of `cache_controller`. It accepts CPU virtual-address load/store requests, translates them through a small fully-associative TLB, and walks a single-level page table on a TLB miss. It then issues the resulting physical request to the cache using the cache's `read_mem`/`write_mem`/`ready_stall` protocol, retrying reads that the cache reports as a refill miss.

---
 rtl/mmu_pkg.sv | 29 ++
 rtl/mmu_translate_tlb_cam.sv | 70 +++++++
 rtl/mmu_translate.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mmu_pkg.sv
`default_nettype none
// ============================================================================
//  mmu_pkg
//  Shared widths, PTE bit positions and FSM state encoding for mmu_translate.
//  Revision: 1.0
// ============================================================================
package mmu_pkg;

    localparam int ADDR_W        = 32;
    localparam int DEF_PAGE_BITS = 12;

    localparam int PTE_VALID    = 0;
    localparam int PTE_WRITABLE = 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LOOKUP     = 3'd1;
    localparam logic [2:0] S_WALK_REQ   = 3'd2;
    localparam logic [2:0] S_WALK_WAIT  = 3'd3;
    localparam logic [2:0] S_ISSUE      = 3'd4;
    localparam logic [2:0] S_WAIT_CACHE = 3'd5;
    localparam logic [2:0] S_RESP       = 3'd6;
    localparam logic [2:0] S_FAULT      = 3'd7;

    function automatic int vpn_width(input int page_bits);
        return ADDR_W - page_bits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmu_translate_tlb_cam.sv
`default_nettype none
// ============================================================================
//  tlb_cam
//  Fully-associative TLB: parallel VPN compare, round-robin fill and flush.
//  Revision: 1.0
// ============================================================================
module tlb_cam #(
    parameter int ENTRIES = 8,
    parameter int VPN_W   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic [VPN_W-1:0] i_vpn,
    output logic             o_hit,
    output logic [VPN_W-1:0] o_ppn,
    output logic             o_writable,
    input  logic             i_fill,
    input  logic [VPN_W-1:0] i_fill_ppn,
    input  logic             i_fill_writable
);
    localparam int PTR_W = $clog2(ENTRIES);

    logic [PTR_W-1:0]   r_ptr;
    logic [ENTRIES-1:0] w_match;
    logic [VPN_W:0]     w_or [ENTRIES+1];

    assign w_or[0] = '0;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        logic             r_valid;
        logic             r_wr;
        logic [VPN_W-1:0] r_tag;
        logic [VPN_W-1:0] r_ppn;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_wr    <= 1'b0;
                r_tag   <= '0;
                r_ppn   <= '0;
            end else if (i_flush) begin
                r_valid <= 1'b0;
            end else if (i_fill && (r_ptr == PTR_W'(i))) begin
                r_valid <= 1'b1;
                r_wr    <= i_fill_writable;
                r_tag   <= i_vpn;
                r_ppn   <= i_fill_ppn;
            end
        end

        assign w_match[i] = r_valid && (r_tag == i_vpn);
        // Fills never duplicate a VPN, so OR-combining the matches is a clean mux
        assign w_or[i+1]  = w_or[i] | (w_match[i] ? {r_wr, r_ppn} : '0);
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_ptr <= '0;
        end else if (i_fill) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_hit      = |w_match;
    assign o_ppn      = w_or[ENTRIES][VPN_W-1:0];
    assign o_writable = w_or[ENTRIES][VPN_W];

endmodule
`default_nettype wire

// File: rtl/mmu_translate.sv
`default_nettype none
// ============================================================================
//  mmu_translate
//  VA->PA translation with TLB, single-level page walk and cache issue FSM.
//  Revision: 1.0
// ============================================================================
module mmu_translate
    import mmu_pkg::*;
#(
    parameter int TLB_ENTRIES = 8,
    parameter int PAGE_BITS   = DEF_PAGE_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_vaddr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_req,
    input  logic        cpu_we,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        page_fault,
    input  logic [31:0] ptbr,
    input  logic        tlb_flush,
    output logic [31:0] phy_addr,
    output logic [31:0] data_from_cpu,
    output logic        read_mem,
    output logic        write_mem,
    input  logic [31:0] cache_data_to_cpu,
    input  logic        cache_ready_stall,
    output logic [31:0] pt_addr,
    output logic        pt_read_req,
    input  logic [31:0] pt_data_in,
    input  logic        pt_ready
);
    localparam int VPN_W = vpn_width(PAGE_BITS);

    logic [2:0]       r_state;
    logic [31:0]      r_vaddr;
    logic [31:0]      r_wdata;
    logic             r_we;
    logic             r_first;
    logic [31:0]      r_phy_addr;
    logic [31:0]      r_pt_addr;

    logic [VPN_W-1:0] w_vpn;
    logic             w_hit;
    logic [VPN_W-1:0] w_ppn;
    logic             w_writable;
    logic             w_flush;
    logic             w_fill;
    logic             w_unused_pte;

    assign w_vpn        = r_vaddr[31:PAGE_BITS];
    assign w_flush      = (r_state == S_IDLE) && tlb_flush;
    assign w_fill       = (r_state == S_WALK_WAIT) && pt_ready && pt_data_in[PTE_VALID];
    assign w_unused_pte = ^pt_data_in[PAGE_BITS-1:PTE_WRITABLE+1];

    tlb_cam #(
        .ENTRIES (TLB_ENTRIES),
        .VPN_W   (VPN_W)
    ) u_tlb (
        .clk             (clk),
        .rst             (rst),
        .i_flush         (w_flush),
        .i_vpn           (w_vpn),
        .o_hit           (w_hit),
        .o_ppn           (w_ppn),
        .o_writable      (w_writable),
        .i_fill          (w_fill),
        .i_fill_ppn      (pt_data_in[31:PAGE_BITS]),
        .i_fill_writable (pt_data_in[PTE_WRITABLE])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_vaddr    <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_first    <= 1'b0;
            r_phy_addr <= '0;
            r_pt_addr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!tlb_flush && cpu_req) begin
                        r_vaddr <= cpu_vaddr;
                        r_wdata <= cpu_wdata;
                        r_we    <= cpu_we;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        r_phy_addr <= {w_ppn, r_vaddr[PAGE_BITS-1:0]};
                        r_state    <= (r_we && !w_writable) ? S_FAULT : S_ISSUE;
                    end else begin
                        r_pt_addr <= ptbr + 32'({w_vpn, 2'b00});
                        r_state   <= S_WALK_REQ;
                    end
                end
                S_WALK_REQ: r_state <= S_WALK_WAIT;
                S_WALK_WAIT: begin
                    if (pt_ready) begin
                        r_state <= pt_data_in[PTE_VALID] ? S_LOOKUP : S_FAULT;
                    end
                end
                S_ISSUE: begin
                    if (!cache_ready_stall) begin
                        r_first <= 1'b1;
                        r_state <= S_WAIT_CACHE;
                    end
                end
                S_WAIT_CACHE: begin
                    r_first <= 1'b0;
                    // A load that stalls on its first cycle was a refill miss: reissue it
                    if (!cache_ready_stall) begin
                        r_state <= (r_we || r_first) ? S_RESP : S_ISSUE;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cpu_rdata     = cache_data_to_cpu;
    assign cpu_done      = (r_state == S_RESP) || (r_state == S_FAULT);
    assign page_fault    = (r_state == S_FAULT);
    assign phy_addr      = r_phy_addr;
    assign data_from_cpu = r_wdata;
    assign read_mem      = (r_state == S_ISSUE) && !cache_ready_stall && !r_we;
    assign write_mem     = (r_state == S_ISSUE) && !cache_ready_stall && r_we;
    assign pt_addr       = r_pt_addr;
    assign pt_read_req   = (r_state == S_WALK_REQ);

endmodule
`default_nettype wire
